// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI write controller:
//   - spi_state_t     : controller FSM states
//   - FRAME_W         : serial frame width (R/W bit + 7-bit addr + 8-bit data)
//   - RW_WRITE        : value of the R/W bit for a register write
//   - ADDR_*          : register map of the attached peripheral
//   - build_write_frame : assembles a write frame from address and data
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int         FRAME_W  = 16;
    localparam logic       RW_WRITE = 1'b1;

    // Peripheral register map. The controller forwards any address
    // unchanged; these names exist for hosts and benches.
    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_DUTY        = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCLK_HI,
        ST_SCLK_LO,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    function automatic logic [FRAME_W-1:0] build_write_frame(
        input logic [6:0] addr,
        input logic [7:0] data
    );
        return {RW_WRITE, addr, data};
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// ---------------------------------------------------------------------------
// spi_tick_gen
// Half-period timer for the SPI controller. While enabled it emits a
// one-cycle tick every CLK_DIV clk cycles; while disabled the count is held
// at zero, so enabling always starts a fresh full period.
//
// Ports:
//   clk    in  : clock
//   rst_n  in  : asynchronous active-low reset
//   enable in  : run the timer
//   tick   out : high on the last cycle of each CLK_DIV-cycle period
// ---------------------------------------------------------------------------
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] count;

    // The count wraps on the tick itself, so the consumer's state change and
    // the start of the next period land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/spi_controller.sv
// ---------------------------------------------------------------------------
// spi_controller
// SPI mode-0 master that turns host register-write requests into 16-bit
// frames {1'b1, addr[6:0], data[7:0]} sent MSB first.
//
// Frame timing (D = CLK_DIV):
//   SETUP  D cycles  ncs=0, sclk=0, sdo=bit 15
//   16 x { SCLK_HI D cycles (sclk=1), SCLK_LO D cycles (sclk=0) }
//   HOLD   D cycles  ncs=0, sclk=0
//   GAP    D cycles  ncs=1, done pulses on the first cycle
// ncs is low for 34*D cycles; done is seen 34*D+1 edges after the accept.
//
// Ports:
//   clk       in  : sole clock, rising edge
//   rst_n     in  : asynchronous active-low reset
//   req_valid in  : host requests a register write
//   req_addr  in  : 7-bit register address
//   req_data  in  : 8-bit write data
//   req_ready out : request can be accepted (IDLE only)
//   done      out : one-cycle pulse when a frame completes
//   sclk      out : SPI clock, mode 0
//   ncs       out : chip select, active-low
//   sdo       out : serial data to the peripheral
// ---------------------------------------------------------------------------
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       done,
    output logic       sclk,
    output logic       ncs,
    output logic       sdo
);

    if ((CLK_DIV < 2) || (CLK_DIV > 255)) begin : g_bad_clk_div
        $error("spi_controller: CLK_DIV must be in 2..255");
    end

    spi_state_t         state;
    spi_state_t         next_state;
    logic               tick;
    logic               accept;
    logic [3:0]         bit_cnt;
    logic [FRAME_W-1:0] shift_reg;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state != ST_IDLE),
        .tick   (tick)
    );

    // req_ready is a register that only rises one edge after reset is
    // released, so qualifying with it keeps the very first edge out of
    // reset from accepting.
    assign accept = (state == ST_IDLE) && req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    next_state = ST_SCLK_HI;
                end
            end
            ST_SCLK_HI: begin
                if (tick) begin
                    next_state = ST_SCLK_LO;
                end
            end
            ST_SCLK_LO: begin
                if (tick) begin
                    next_state = (bit_cnt == 4'd15) ? ST_HOLD : ST_SCLK_HI;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Pin outputs are registered from the next-state decode so they switch
    // on the same edge as the state and never depend combinationally on
    // the request inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            done      <= 1'b0;
            sclk      <= 1'b0;
            ncs       <= 1'b1;
        end else begin
            req_ready <= (next_state == ST_IDLE);
            done      <= (state == ST_HOLD) && tick;
            sclk      <= (next_state == ST_SCLK_HI);
            ncs       <= (next_state == ST_IDLE) || (next_state == ST_GAP);
        end
    end

    // The shift register feeds sdo from its MSB. Shifting happens as the
    // controller enters SCLK_LO (the SCLK falling edge) and fills with
    // zeros, so after the 16th shift the register is empty and sdo rests
    // at 0 through HOLD, GAP and IDLE without extra gating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else if (accept) begin
            shift_reg <= build_write_frame(req_addr, req_data);
        end else if ((state == ST_SCLK_HI) && tick) begin
            shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
        end
    end

    // bit_cnt holds the index of the SCLK pulse in progress; the 16th
    // SCLK_LO period ends the data phase when it reads 15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (accept) begin
            bit_cnt <= '0;
        end else if ((state == ST_SCLK_LO) && tick && (bit_cnt != 4'd15)) begin
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    assign sdo = shift_reg[FRAME_W-1];

endmodule

// File: tb/tb_spi_controller.sv
// ---------------------------------------------------------------------------
// tb_spi_controller
// Self-checking bench for spi_controller. A CLK_DIV=4 instance is compared
// every cycle against a frame-offset model; a CLK_DIV=2 instance is used for
// a latency/bit check. A bench-side SPI receiver decodes frames into a
// register array and a scoreboard of accepted requests.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_controller;
    import spi_pkg::*;

    localparam int DIV  = 4;
    localparam int DIV2 = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       req_ready, done, sclk, ncs, sdo;

    logic       req_valid2;
    logic [6:0] req_addr2;
    logic [7:0] req_data2;
    logic       req_ready2, done2, sclk2, ncs2, sdo2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    spi_controller #(.CLK_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .done      (done),
        .sclk      (sclk),
        .ncs       (ncs),
        .sdo       (sdo)
    );

    spi_controller #(.CLK_DIV(DIV2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid2),
        .req_addr  (req_addr2),
        .req_data  (req_data2),
        .req_ready (req_ready2),
        .done      (done2),
        .sclk      (sclk2),
        .ncs       (ncs2),
        .sdo       (sdo2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference model: tracks only "idle" or "k cycles since accept" plus
    // the latched frame; outputs are derived from frame arithmetic.
    logic        m_active, m_ready;
    int          m_k;
    logic [15:0] m_frame;
    logic [15:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_ready  <= 1'b0;
            m_k      <= 0;
            m_frame  <= '0;
            exp_q.delete();
        end else if (!m_active) begin
            if (req_valid && m_ready) begin
                m_active <= 1'b1;
                m_ready  <= 1'b0;
                m_k      <= 0;
                m_frame  <= {1'b1, req_addr, req_data};
                exp_q.push_back({1'b1, req_addr, req_data});
            end else begin
                m_ready <= 1'b1;
            end
        end else if (m_k == 35 * DIV - 1) begin
            m_active <= 1'b0;
            m_ready  <= 1'b1;
        end else begin
            m_k <= m_k + 1;
        end
    end

    // Returns {req_ready, done, sclk, ncs, sdo}. Half-period 0 is SETUP,
    // 1..32 alternate high/low SCLK, 33 is HOLD, 34 is GAP.
    function automatic logic [4:0] model_outputs(input logic active, input logic ready,
                                                 input int k, input logic [15:0] fr);
        int half, j, i;
        if (!active) return {ready, 1'b0, 1'b0, 1'b1, 1'b0};
        half = k / DIV;
        if (half >= 34) return {1'b0, (k == 34 * DIV), 1'b0, 1'b1, 1'b0};
        if (half == 33) return 5'b00000;
        if (half == 0)  return {4'b0000, fr[15]};
        j = half - 1;
        i = j / 2;
        if (j % 2 == 0) return {3'b001, 1'b0, fr[15 - i]};
        return {4'b0000, (i == 15) ? 1'b0 : fr[14 - i]};
    endfunction

    always @(negedge clk) begin
        logic [4:0] e;
        e = model_outputs(m_active, m_ready, m_k, m_frame);
        checkOutput("req_ready", {31'd0, req_ready}, {31'd0, e[4]});
        checkOutput("done",      {31'd0, done},      {31'd0, e[3]});
        checkOutput("sclk",      {31'd0, sclk},      {31'd0, e[2]});
        checkOutput("ncs",       {31'd0, ncs},       {31'd0, e[1]});
        checkOutput("sdo",       {31'd0, sdo},       {31'd0, e[0]});
    end

    // Bench-side SPI receiver standing in for the peripheral.
    logic [15:0] dec_shift = '0;
    logic [15:0] last_frame = '0;
    int          dec_bits = 0, low_cnt = 0, high_cnt = 0, last_low = 0, last_gap = 0;
    int          done_cnt = 0;
    logic        prev_sclk = 1'b0, prev_ncs = 1'b1;
    logic [7:0]  regs [0:127];

    always @(negedge clk) begin
        if (!rst_n) begin
            dec_bits  <= 0;
            low_cnt   <= 0;
            high_cnt  <= 0;
            prev_sclk <= 1'b0;
            prev_ncs  <= 1'b1;
        end else begin
            prev_sclk <= sclk;
            prev_ncs  <= ncs;
            if (done) done_cnt <= done_cnt + 1;
            if (sclk && !prev_sclk && !ncs) begin
                dec_shift <= {dec_shift[14:0], sdo};
                dec_bits  <= dec_bits + 1;
            end
            if (!ncs) low_cnt <= low_cnt + 1;
            else      high_cnt <= high_cnt + 1;
            if (!ncs && prev_ncs) begin
                last_gap <= high_cnt;
                high_cnt <= 0;
                low_cnt  <= 1;
                dec_bits <= 0;
            end
            if (ncs && !prev_ncs) begin
                last_low <= low_cnt;
                high_cnt <= 1;
                checkOutput("frame_bits", dec_bits, 16);
                if (dec_bits == 16) begin
                    last_frame <= dec_shift;
                    if (dec_shift[15]) regs[dec_shift[14:8]] <= dec_shift[7:0];
                    if (exp_q.size() == 0) checkOutput("frame_unexpected", 1, 0);
                    else checkOutput("frame", {16'd0, dec_shift}, {16'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] a, input logic [7:0] d, input bit keep_valid);
        int b = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && b < 400) begin
            tick();
            b++;
        end
        if (b >= 400) checkOutput("accept_timeout", 0, 1);
        tick();
        if (!keep_valid) req_valid = 1'b0;
    endtask

    // Scrambles the request bus while busy to show it is ignored.
    task automatic waitDoneCount(input int target);
        int b = 0;
        while (done_cnt < target && b < 1000) begin
            tick();
            req_addr = 7'($urandom);
            req_data = 8'($urandom);
            b++;
        end
        if (b >= 1000) checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int d0, b, t0, t1, nbits;
        logic [7:0]  saved;
        logic [15:0] cap;
        logic        p2;

        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_data = '0;
        req_valid2 = 1'b0; req_addr2 = '0; req_data2 = '0;
        repeat (3) tick();

        $display("[TB] reset checks");
        checkOutput("reset_ncs",   {31'd0, ncs},       1);
        checkOutput("reset_sclk",  {31'd0, sclk},      0);
        checkOutput("reset_ready", {31'd0, req_ready}, 0);
        checkOutput("reset_done",  {31'd0, done},      0);
        rst_n = 1'b1;
        tick();
        checkOutput("ready_after_reset", {31'd0, req_ready}, 1);

        $display("[TB] bit-level frame 0x00/0xA5");
        applyStimulus(ADDR_EN_OUT_7_0, 8'hA5, 1'b0);
        waitDoneCount(1);
        checkOutput("bit_frame", {16'd0, last_frame}, 32'h80A5);
        checkOutput("ncs_low_cycles", last_low, 136);

        $display("[TB] loopback writes");
        applyStimulus(ADDR_DUTY, 8'h80, 1'b0);
        waitDoneCount(2);
        checkOutput("reg_duty", {24'd0, regs[ADDR_DUTY]}, 32'h80);
        applyStimulus(ADDR_EN_PWM_7_0, 8'hFF, 1'b0);
        waitDoneCount(3);
        checkOutput("reg_en_pwm_7_0", {24'd0, regs[ADDR_EN_PWM_7_0]}, 32'hFF);

        $display("[TB] back-to-back with busy bus changes");
        d0 = done_cnt;
        applyStimulus(ADDR_EN_OUT_15_8, 8'h11, 1'b1);
        applyStimulus(ADDR_EN_PWM_15_8, 8'h22, 1'b0);
        waitDoneCount(d0 + 2);
        checkOutput("b2b_done_count", done_cnt - d0, 2);
        checkOutput("b2b_gap_min", {31'd0, (last_gap >= DIV + 1)}, 1);
        checkOutput("reg_en_out_15_8", {24'd0, regs[ADDR_EN_OUT_15_8]}, 32'h11);
        checkOutput("reg_en_pwm_15_8", {24'd0, regs[ADDR_EN_PWM_15_8]}, 32'h22);

        $display("[TB] reset mid-frame");
        saved = regs[7'h05];
        d0 = done_cnt;
        applyStimulus(7'h05, 8'h77, 1'b0);
        b = 0;
        while (dec_bits < 8 && b < 400) begin
            tick();
            b++;
        end
        if (b >= 400) checkOutput("sclk_edge_timeout", 0, 1);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ncs",   {31'd0, ncs},       1);
        checkOutput("abort_sclk",  {31'd0, sclk},      0);
        checkOutput("abort_done",  {31'd0, done},      0);
        checkOutput("abort_ready", {31'd0, req_ready}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checkOutput("abort_reg_kept", {24'd0, regs[7'h05]}, {24'd0, saved});
        checkOutput("abort_no_done", done_cnt, d0);
        checkOutput("abort_ready_back", {31'd0, req_ready}, 1);

        $display("[TB] CLK_DIV=2 frame 0x01/0x3C");
        req_valid2 = 1'b1; req_addr2 = 7'h01; req_data2 = 8'h3C;
        b = 0;
        while (!req_ready2 && b < 100) begin
            tick();
            b++;
        end
        if (b >= 100) checkOutput("accept2_timeout", 0, 1);
        t0 = cyc;
        tick();
        req_valid2 = 1'b0;
        req_addr2 = 7'h7F; req_data2 = 8'h00;
        cap = '0; nbits = 0; p2 = 1'b0; b = 0;
        while (!done2 && b < 500) begin
            if (sclk2 && !p2) begin
                cap = {cap[14:0], sdo2};
                nbits++;
            end
            p2 = sclk2;
            tick();
            b++;
        end
        if (b >= 500) checkOutput("done2_timeout", 0, 1);
        t1 = cyc;
        checkOutput("div2_latency", t1 - t0, 69);
        checkOutput("div2_bits", nbits, 16);
        checkOutput("div2_frame", {16'd0, cap}, 32'h813C);
        tick();
        checkOutput("div2_done_pulse", {31'd0, done2}, 0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 4000; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = 7'($urandom);
            req_data  = 8'($urandom);
            if (n == 2345) begin
                rst_n = 1'b0;
                repeat (2) tick();
                rst_n = 1'b1;
            end
            tick();
        end
        req_valid = 1'b0;
        b = 0;
        while (!req_ready && b < 400) begin
            tick();
            b++;
        end
        if (b >= 400) checkOutput("drain_timeout", 0, 1);
        repeat (3) tick();
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  host requests a register write.
REQ-005 SHALL have port req_addr  input  7  target register address.
REQ-006 SHALL have port req_data  input  8  write data.
REQ-007 SHALL have port req_ready  output  1  controller can accept a request.
REQ-008 SHALL have port done  output  1  one-cycle pulse when a frame completes.
REQ-009 SHALL have port sclk  output  1  SPI clock, mode 0; drives the peripheral's sclk (ui_in[0]).
REQ-010 SHALL have port ncs  output  1  chip select, active-low; drives the peripheral's ncs (ui_in[1]).
REQ-011 SHALL have port sdo  output  1  serial data out; drives the peripheral's sdi (ui_in[2]).

Function
REQ-012 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, latching frame = {1'b1 (write), req_addr, req_data}, 16 bits.
REQ-013 SHALL transmit the frame MSB first: bit 15 is the R/W bit, bits 14:8 the address, bits 7:0 the data.
REQ-014 SHALL implement the FSM IDLE -> SETUP -> SCLK_HI <-> SCLK_LO -> HOLD -> GAP -> IDLE.
REQ-015 SHALL stay in IDLE with ncs=1, sclk=0, sdo=0 and req_ready=1.
REQ-016 SHALL, on accept, enter SETUP the next cycle: ncs=0, sdo=frame[15], sclk=0, held for CLK_DIV cycles.
REQ-017 SHALL in SCLK_HI drive sclk=1 for CLK_DIV cycles, with sdo held stable.
REQ-018 SHALL in SCLK_LO drive sclk=0 for CLK_DIV cycles; sdo SHALL change only on entry to SCLK_LO (falling edge) to the next bit.
REQ-019 SHALL produce exactly 16 SCLK rising edges per frame, counted by a 4-bit bit counter.
REQ-020 SHALL go to HOLD after the 16th SCLK_LO period: ncs=0, sclk=0 for CLK_DIV cycles.
REQ-021 SHALL enter GAP after HOLD: ncs=1 and sdo=0 for CLK_DIV cycles, pulsing done for the first GAP cycle.
REQ-022 SHALL hold ncs low for exactly 34*CLK_DIV cycles per frame; accept-to-done latency SHALL be 34*CLK_DIV+1 cycles.
REQ-023 SHALL drive req_ready=0 in every state except IDLE; req_addr and req_data SHALL be ignored while busy.
REQ-024 SHALL, when req_valid is held high, start back-to-back frames separated by at least CLK_DIV+1 cycles of ncs=1.
REQ-025 SHALL pass any address 0x00..0x7F unchanged; decode and range checking belong to the peripheral.
REQ-026 SHALL generate all outputs from registers, with no combinational path from inputs to sclk, ncs or sdo.

Reset
REQ-027 SHALL on rst_n=0 immediately force FSM=IDLE, ncs=1, sclk=0, sdo=0, done=0, req_ready=0, and clear all counters and the shift register.
REQ-028 SHALL abort a frame if reset occurs mid-frame, with no partial done pulse; req_ready SHALL rise on the first clk edge after rst_n deasserts.

Structure
REQ-029 SHALL take the FSM state enum, FRAME_W=16, RW_WRITE=1'b1 and the register address constants (0x00 en_out_7_0, 0x01 en_out_15_8, 0x02 en_pwm_7_0, 0x03 en_pwm_15_8, 0x04 duty) from shared package spi_pkg.
REQ-030 SHALL place the CLK_DIV half-period counter in sub-module spi_tick_gen, which outputs a one-cycle tick every CLK_DIV cycles while enabled and restarts on enable.

Verification
REQ-031 Bit-level: CLK_DIV=4, write addr 0x00 data 0xA5 -> sdo sampled on sclk rising edges = 1,0000000,10100101; ncs low for 136 cycles.
REQ-032 Loopback with spi_peripheral: write 0x04/0x80 then 0x02/0xFF -> pwm_duty_cycle=0x80 and en_reg_pwm_7_0=0xFF after each done.
REQ-033 Back-to-back: req_valid held high with two requests -> two frames, ncs high for at least 5 cycles between them, two done pulses.
REQ-034 Reset mid-frame: assert rst_n=0 after the 8th SCLK edge -> ncs=1 and sclk=0 immediately, no done, peripheral registers unchanged.
REQ-035 Busy ignore: change req_addr and req_data mid-frame -> transmitted bits still match the latched request.
REQ-036 CLK_DIV=2: write 0x01/0x3C -> en_reg_out_15_8=0x3C; accept-to-done = 69 cycles.
